// File: rtl/sm83_pkg.sv
// Shared sm83 bus definitions: OAM DMA state encoding and default register/region constants.
package sm83_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RD,
        WR
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int          OAM_DMA_LEN  = 160;

endpackage

// File: rtl/oam_dma_arbiter.sv
// Single CPU-side memory port shared by the sm83 core and the OAM DMA engine.
// While a copy is running the engine owns the port; CPU accesses stall except the DMA register.
module oam_dma_arbiter
    import sm83_pkg::*;
#(
    parameter int          DMA_LEN  = OAM_DMA_LEN,
    parameter logic [15:0] DST_BASE = OAM_BASE,
    parameter logic [15:0] REG_ADDR = DMA_REG_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_stall,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active
);

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    dma_state_t state_q, state_d;
    logic [7:0] src_hi_q;
    logic [7:0] idx_q;
    logic [7:0] byte_q;

    logic reg_hit;
    logic reg_wr;

    assign reg_hit    = (cpu_addr == REG_ADDR);
    assign reg_wr     = cpu_req & cpu_we & reg_hit;
    assign dma_active = (state_q != IDLE);
    assign cpu_stall  = cpu_req & dma_active & ~reg_hit;
    assign cpu_rdata  = reg_hit ? src_hi_q : mem_rdata;

    // A register write restarts the copy from any state, including mid-transfer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = IDLE;
            ARM:  state_d = RD;
            RD:   state_d = WR;
            WR:   state_d = (idx_q == LAST_IDX) ? IDLE : RD;
            default: state_d = IDLE;
        endcase
        if (reg_wr) begin
            state_d = ARM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            src_hi_q <= 8'h00;
            idx_q    <= 8'h00;
            byte_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            if (reg_wr) begin
                src_hi_q <= cpu_wdata;
                idx_q    <= 8'h00;
            end else if (state_q == WR) begin
                idx_q <= idx_q + 8'd1;
            end
            if (state_q == RD) begin
                byte_q <= mem_rdata;
            end
        end
    end

    // Port mux: CPU passthrough when idle, engine addresses otherwise.
    always_comb begin
        mem_addr  = 16'h0000;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        unique case (state_q)
            IDLE: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_req & cpu_we & ~reg_hit;
            end
            ARM: begin
                mem_addr = 16'h0000;
            end
            RD: begin
                mem_addr = {src_hi_q, idx_q};
            end
            WR: begin
                mem_addr  = DST_BASE + {8'h00, idx_q};
                mem_we    = 1'b1;
                mem_wdata = byte_q;
            end
            default: begin
                mem_addr = 16'h0000;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter with a behavioural 64 KiB memory on the port.
module tb_oam_dma_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_stall;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        dma_active;

    logic [7:0] mem [0:65535];

    int checks;
    int errors;

    oam_dma_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .dma_active (dma_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic bus_idle();
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
    endtask

    task automatic clear_oam();
        for (int i = 0; i < 256; i++) mem[16'hFE00 + i] = 8'hEE;
    endtask

    // Issues the register write at a negedge; returns just after the posedge that accepts it.
    task automatic start_dma(input logic [7:0] hi);
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 16'hFF46;
        cpu_wdata = hi;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reg_write_mem_we got %b want 0", mem_we);
        end
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!dma_active) break;
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_idle();
        cpu_req  = 1'b1;
        cpu_addr = 16'hFF46;
        #1;
        checks++;
        if (dma_active !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_state active=%b stall=%b want 0/0", dma_active, cpu_stall);
        end
        checks++;
        if (cpu_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_src_hi got %h want 00", cpu_rdata);
        end
        bus_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 16'h1234;
        #1;
        checks++;
        if (cpu_rdata !== 8'h5A || cpu_stall !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h1234) begin
            errors++;
            $display("FAIL idle_read rdata=%h stall=%b we=%b addr=%h want 5a/0/0/1234",
                     cpu_rdata, cpu_stall, mem_we, mem_addr);
        end
        cpu_we    = 1'b1;
        cpu_addr  = 16'h2000;
        cpu_wdata = 8'h3C;
        #1;
        checks++;
        if (mem_we !== 1'b1 || mem_wdata !== 8'h3C) begin
            errors++;
            $display("FAIL idle_write we=%b wdata=%h want 1/3c", mem_we, mem_wdata);
        end
        @(posedge clk);
        #1;
        bus_idle();
        checks++;
        if (mem[16'h2000] !== 8'h3C) begin
            errors++;
            $display("FAIL idle_write_mem got %h want 3c", mem[16'h2000]);
        end
    endtask

    task automatic test_copy();
        int n;
        int bad;
        clear_oam();
        start_dma(8'hC1);
        @(negedge clk);
        checks++;
        if (dma_active !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL arm_cycle active=%b we=%b addr=%h want 1/0/0000", dma_active, mem_we, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (mem_addr !== 16'hC100 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL first_rd addr=%h we=%b want c100/0", mem_addr, mem_we);
        end
        @(negedge clk);
        checks++;
        if (mem_addr !== 16'hFE00 || mem_we !== 1'b1 || mem_wdata !== 8'h00) begin
            errors++;
            $display("FAIL first_wr addr=%h we=%b wdata=%h want fe00/1/00", mem_addr, mem_we, mem_wdata);
        end
        wait_idle(n);
        checks++;
        if (n + 3 !== 321) begin
            errors++;
            $display("FAIL active_cycles got %0d want 321", n + 3);
        end
        bad = 0;
        for (int i = 0; i < 160; i++) if (mem[16'hFE00 + i] !== 8'(i)) bad++;
        checks++;
        if (bad != 0 || mem[16'hFEA0] !== 8'hEE) begin
            errors++;
            $display("FAIL copy_c1 bad_bytes=%0d fea0=%h want 0/ee", bad, mem[16'hFEA0]);
        end
    endtask

    task automatic test_stall();
        int stalls;
        int bad;
        clear_oam();
        start_dma(8'hC2);
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 16'hC000;
        #1;
        stalls = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!cpu_stall) break;
            stalls++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (stalls !== 321) begin
            errors++;
            $display("FAIL stall_cycles got %0d want 321", stalls);
        end
        checks++;
        if (cpu_rdata !== 8'h77 || dma_active !== 1'b0) begin
            errors++;
            $display("FAIL stalled_read rdata=%h active=%b want 77/0", cpu_rdata, dma_active);
        end
        cpu_req = 1'b0;
        #1;
        checks++;
        if (cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL no_req_stall got %b want 0", cpu_stall);
        end
        bus_idle();
        bad = 0;
        for (int i = 0; i < 160; i++) if (mem[16'hFE00 + i] !== ~8'(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL copy_c2 bad_bytes=%0d want 0", bad);
        end
    endtask

    task automatic test_reg_read_mid_dma();
        int n;
        int bad;
        clear_oam();
        start_dma(8'hC1);
        repeat (40) @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 16'hFF46;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (cpu_rdata !== 8'hC1 || cpu_stall !== 1'b0 || dma_active !== 1'b1) begin
                errors++;
                $display("FAIL reg_read_mid rdata=%h stall=%b active=%b want c1/0/1",
                         cpu_rdata, cpu_stall, dma_active);
            end
            @(negedge clk);
        end
        bus_idle();
        wait_idle(n);
        bad = 0;
        for (int i = 0; i < 160; i++) if (mem[16'hFE00 + i] !== 8'(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL copy_after_reg_read bad_bytes=%0d want 0", bad);
        end
    endtask

    task automatic test_restart();
        int n;
        int bad;
        clear_oam();
        start_dma(8'hC1);
        repeat (101) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_addr !== 16'hC132 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL restart_rd_idx50 addr=%h we=%b want c132/0", mem_addr, mem_we);
        end
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 16'hFF46;
        cpu_wdata = 8'hD0;
        #1;
        checks++;
        if (cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL restart_stall got %b want 0", cpu_stall);
        end
        @(posedge clk);
        #1;
        bus_idle();
        checks++;
        if (mem[16'hFE31] !== 8'h31 || mem[16'hFE32] !== 8'hEE || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL restart_partial fe31=%h fe32=%h addr=%h want 31/ee/0000",
                     mem[16'hFE31], mem[16'hFE32], mem_addr);
        end
        wait_idle(n);
        checks++;
        if (n !== 321) begin
            errors++;
            $display("FAIL restart_active_cycles got %0d want 321", n);
        end
        bad = 0;
        for (int i = 0; i < 160; i++) if (mem[16'hFE00 + i] !== 8'(i + 64)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL copy_d0 bad_bytes=%0d want 0", bad);
        end
    endtask

    task automatic test_reset_mid_dma();
        int bad;
        clear_oam();
        start_dma(8'hC1);
        repeat (21) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_addr !== 16'hC10A) begin
            errors++;
            $display("FAIL rd_idx10 addr=%h want c10a", mem_addr);
        end
        rst_n    = 1'b0;
        cpu_req  = 1'b1;
        cpu_addr = 16'hC000;
        #1;
        checks++;
        if (dma_active !== 1'b0 || cpu_stall !== 1'b0 || cpu_rdata !== 8'h77) begin
            errors++;
            $display("FAIL async_reset active=%b stall=%b rdata=%h want 0/0/77",
                     dma_active, cpu_stall, cpu_rdata);
        end
        bus_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 10; i++) if (mem[16'hFE00 + i] !== 8'(i)) bad++;
        for (int i = 10; i < 160; i++) if (mem[16'hFE00 + i] !== 8'hEE) bad++;
        checks++;
        if (bad != 0 || dma_active !== 1'b0) begin
            errors++;
            $display("FAIL reset_partial_oam bad_bytes=%0d active=%b want 0/0", bad, dma_active);
        end
        cpu_req  = 1'b1;
        cpu_addr = 16'hFF46;
        #1;
        checks++;
        if (cpu_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_src_hi_after got %h want 00", cpu_rdata);
        end
        bus_idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1234] = 8'h5A;
        mem[16'hC000] = 8'h77;
        for (int i = 0; i < 256; i++) begin
            mem[16'hC100 + i] = 8'(i);
            mem[16'hC200 + i] = ~8'(i);
            mem[16'hD000 + i] = 8'(i + 64);
        end
        test_reset();
        test_copy();
        test_stall();
        test_reg_read_mid_dma();
        test_restart();
        test_reset_mid_dma();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
